pair_match_sequencer: RTL and testbench



---
 rtl/pair_match_sequencer.sv | 148 ++++++++++++++
 tb/tb_pair_match_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pair_match_sequencer.sv
// pair_match_sequencer
//
// Compares two W-bit operands two bits at a time, starting with the least
// significant pair. A single shared 2-bit cell evaluates one pair per clock.
// A pair "hits" when at least one of its two bit positions holds the same
// value in both operands. When the run ends the block reports a per-pair
// hit mask, the number of hits, and a flag that is set when every pair hit.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      request an evaluation; taken only while ready=1
//   abort      synchronous cancel; also blocks a start in the same cycle
//   x, y       operands, captured when start is taken
//   ready      high while idle and able to take a start
//   done       one-cycle pulse when hit_mask/hit_count/all_hit are final
//   hit_mask   bit i = hit result of slice i (bits 2i+1:2i)
//   hit_count  number of set bits in hit_mask
//   all_hit    every slice hit; updated together with done and held after

module pair_match_sequencer #(
  parameter int W  = 8,
  parameter int NS = W / 2,
  parameter int CW = $clog2(NS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  x,
  input  logic [W-1:0]  y,
  output logic          ready,
  output logic          done,
  output logic [NS-1:0] hit_mask,
  output logic [CW-1:0] hit_count,
  output logic          all_hit
);

  // Slice index width; kept at least one bit so that NS=1 still elaborates.
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [W-1:0]  xr;
  logic [W-1:0]  yr;

  logic [1:0]    pair_eq;
  logic          hit;
  logic [NS-1:0] mask_next;

  // Shared pair-match cell: selects slice idx of the captured operands.
  // {idx, 1'b0} is 2*idx, i.e. the low bit of the current pair.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    pair_eq        = xr[{idx, 1'b0} +: 2] ~^ yr[{idx, 1'b0} +: 2];
    hit            = |pair_eq;
    mask_next      = hit_mask;
    mask_next[idx] = hit;
  end

  // ready and done come straight from flops; they are updated alongside the
  // state so that no input reaches an output through logic in one cycle.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values that were present before the clock edge.
  // NOTE: the operand registers are reset along with everything else; they
  // are only a few flops, and this keeps the cell output known after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      xr        <= '0;
      yr        <= '0;
      ready     <= 1'b1;
      done      <= 1'b0;
      hit_mask  <= '0;
      hit_count <= '0;
      all_hit   <= 1'b0;
    end else begin
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (abort) begin
            // An abort while idle also clears the held results; a start
            // presented in the same cycle is dropped.
            hit_mask  <= '0;
            hit_count <= '0;
            all_hit   <= 1'b0;
          end else if (start) begin
            xr        <= x;
            yr        <= y;
            idx       <= '0;
            hit_mask  <= '0;
            hit_count <= '0;
            all_hit   <= 1'b0;
            ready     <= 1'b0;
            state     <= RUN;
          end
        end

        RUN: begin
          if (abort) begin
            hit_mask  <= '0;
            hit_count <= '0;
            all_hit   <= 1'b0;
            ready     <= 1'b1;
            state     <= IDLE;
          end else begin
            hit_mask  <= mask_next;
            hit_count <= hit_count + CW'(hit);
            if (idx == IW'(NS - 1)) begin
              // all_hit must see this cycle's slice, so it is taken from the
              // updated mask rather than the registered one.
              all_hit <= &mask_next;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        DONE: begin
          // done was asserted on entry and drops here; ready returns so the
          // earliest new start is taken one cycle after the done pulse.
          ready <= 1'b1;
          state <= IDLE;
          if (abort) begin
            hit_mask  <= '0;
            hit_count <= '0;
            all_hit   <= 1'b0;
          end
        end

        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pair_match_sequencer.sv
// Testbench for pair_match_sequencer (W=8, four slices).
// Stimulus pushes hand-computed results into a queue; a monitor pops and
// compares them whenever done is seen.

module tb_pair_match_sequencer;

  localparam int W  = 8;
  localparam int NS = W / 2;
  localparam int CW = $clog2(NS + 1);

  typedef struct packed {
    logic [NS-1:0] mask;
    logic [CW-1:0] cnt;
    logic          all;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [W-1:0]  x;
  logic [W-1:0]  y;
  logic          ready;
  logic          done;
  logic [NS-1:0] hit_mask;
  logic [CW-1:0] hit_count;
  logic          all_hit;

  exp_t sb[$];
  int   total_cnt = 0;
  int   pass_cnt  = 0;
  int   done_seen = 0;

  pair_match_sequencer #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .x         (x),
    .y         (y),
    .ready     (ready),
    .done      (done),
    .hit_mask  (hit_mask),
    .hit_count (hit_count),
    .all_hit   (all_hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_seen++;
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          check("hit_mask",  32'(hit_mask),  32'(e.mask));
          check("hit_count", 32'(hit_count), 32'(e.cnt));
          check("all_hit",   32'(all_hit),   32'(e.all));
        end
      end
    end
  end

  // Count negedges until done is seen; n is the negedge number it was seen on.
  task automatic wait_done(output int n);
    bit found = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        n = i;
        found = 1'b1;
        break;
      end
    end
    if (!found) check("done_timeout", 32'd0, 32'd1);
  endtask

  // One normal run from IDLE. Optionally scrambles x/y right after acceptance.
  task automatic run_one(input logic [W-1:0] xa, input logic [W-1:0] ya,
                         input logic [NS-1:0] m, input logic [CW-1:0] c,
                         input logic a, input bit scramble, input string tag);
    int n;
    exp_t e;
    @(posedge clk); #1;
    x = xa; y = ya; start = 1'b1;
    e.mask = m; e.cnt = c; e.all = a;
    sb.push_back(e);
    @(posedge clk); #1;   // accepting edge T0
    start = 1'b0;
    check({tag, "_ready_low"}, 32'(ready), 32'd0);
    if (scramble) begin
      x = ~xa; y = 8'h3C;
    end
    wait_done(n);
    check({tag, "_latency"}, 32'(n), 32'(NS + 1));
    @(posedge clk); #1;
    check({tag, "_ready_back"}, 32'(ready), 32'd1);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n1, n2, seen_before;

    rst = 1'b1; start = 1'b0; abort = 1'b0; x = '0; y = '0;
    #1;
    check("rst_ready",     32'(ready),     32'd1);
    check("rst_done",      32'(done),      32'd0);
    check("rst_hit_mask",  32'(hit_mask),  32'd0);
    check("rst_hit_count", 32'(hit_count), 32'd0);
    check("rst_all_hit",   32'(all_hit),   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Equal operands: every slice hits.
    run_one(8'hA5, 8'hA5, 4'b1111, 3'd4, 1'b1, 1'b0, "eq");
    // Complement: no bit position matches anywhere.
    run_one(8'hA5, 8'h5A, 4'b0000, 3'd0, 1'b0, 1'b0, "cmp");
    // Only slice 2 (bits 5:4) has matching bits; operands changed mid-run.
    run_one(8'hA5, 8'h6A, 4'b0100, 3'd1, 1'b0, 1'b1, "mix");
    check("hold_mask_idle", 32'(hit_mask), 32'h4);

    // Start held high across two runs: second is taken the cycle after done.
    @(posedge clk); #1;
    x = 8'hA5; y = 8'h6A; start = 1'b1;
    sb.push_back('{mask: 4'b0100, cnt: 3'd1, all: 1'b0});
    sb.push_back('{mask: 4'b0100, cnt: 3'd1, all: 1'b0});
    @(posedge clk);
    wait_done(n1);
    check("b2b_first_latency", 32'(n1), 32'(NS + 1));
    wait_done(n2);
    start = 1'b0;
    check("b2b_period", 32'(n2), 32'(NS + 2));
    @(posedge clk); #1;

    // Abort on the second RUN cycle (A5/A5: slice 0 already recorded a hit).
    seen_before = done_seen;
    @(posedge clk); #1;
    x = 8'hA5; y = 8'hA5; start = 1'b1;
    @(posedge clk); #1;   // T0
    start = 1'b0;
    @(posedge clk); #1;   // T1: slice 0 written
    check("abort_partial_mask", 32'(hit_mask), 32'h1);
    abort = 1'b1;
    @(posedge clk); #1;   // T2: abort taken
    abort = 1'b0;
    check("abort_ready",     32'(ready),     32'd1);
    check("abort_hit_mask",  32'(hit_mask),  32'd0);
    check("abort_hit_count", 32'(hit_count), 32'd0);
    check("abort_all_hit",   32'(all_hit),   32'd0);
    // Start together with abort in IDLE is not taken.
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("start_with_abort_ready", 32'(ready), 32'd1);
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_seen), 32'(seen_before));

    // Asynchronous reset in the middle of a run.
    @(posedge clk); #1;
    x = 8'hA5; y = 8'hA5; start = 1'b1;
    @(posedge clk); #1;   // T0
    start = 1'b0;
    @(posedge clk); #1;   // T1
    @(posedge clk); #3;   // between T2 and the next edge
    rst = 1'b1;
    #1;
    check("arst_ready",     32'(ready),     32'd1);
    check("arst_done",      32'(done),      32'd0);
    check("arst_hit_mask",  32'(hit_mask),  32'd0);
    check("arst_hit_count", 32'(hit_count), 32'd0);
    check("arst_all_hit",   32'(all_hit),   32'd0);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("arst_no_done", 32'(done_seen), 32'(seen_before));
    run_one(8'hA5, 8'h5A, 4'b0000, 3'd0, 1'b0, 1'b0, "post_rst");

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Global watchdog so the bench can never hang.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
